mcp49xx_dac_driver: RTL and testbench

Parametrised SPI driver for the MCP49xx DAC family: MCP4901/4911/4921 single-channel and MCP4902/4912/4922 dual-channel, at 8/10/12-bit resolution. On each rising edge of sample_clk it latches every enabled channel's sample and shifts one 16-bit write frame per channel, MSB first, SPI mode 0. It then pulses LDAC_n so all channels update simultaneously. The SPI bit engine is internal and needs no external SPI master. It sits between the synth voice/mixer outputs and the DAC pins.

---
 rtl/mcp49xx_dac_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_mcp49xx_dac_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcp49xx_dac_driver.sv
// MCP49xx SPI DAC driver: on each sample_clk rise, sends one 16-bit frame per enabled channel, then pulses LDAC_n.
// CS_PIN falls 3 clk after the synchronised rise. There is no backpressure: an edge that arrives while busy is dropped and sets overrun.
module mcp49xx_dac_driver #(
    parameter int DATA_WIDTH  = 10,
    parameter int NUM_CH      = 1,
    parameter int CLK_DIV     = 2,
    parameter int LDAC_CYCLES = 2,
    parameter int BUFFERED    = 0,
    parameter int GAIN_1X     = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_clk,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            ch_shdn,
    output logic                         SCK_PIN,
    output logic                         MOSI_PIN,
    output logic                         CS_PIN,
    output logic                         LDAC_PIN,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int CNT_MAX = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_CYCLES - 1);
    localparam logic BUF_BIT  = (BUFFERED != 0);
    localparam logic GAIN_BIT = (GAIN_1X != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    state_t                       state, state_n;
    logic   [CW-1:0]              cnt, cnt_n;
    logic   [3:0]                 bit_idx, bit_n;
    logic                         sck_hi, sck_n;
    logic   [15:0]                sh, sh_n;
    logic                         ch, ch_n;
    logic   [1:0]                 en_q, en_n;
    logic   [1:0]                 shdn_q, shdn_n;
    logic   [1:0][DATA_WIDTH-1:0] data_q, data_n;
    logic                         done_q, done_n;
    logic                         ovr_q, ovr_n;
    logic                         sync1, sync2, sync3;
    logic                         rise;
    logic                         div_end;

    // Inputs widened to two channels so single-channel parts share one datapath.
    logic [1:0]                 en_in;
    logic [1:0]                 shdn_in;
    logic [1:0][DATA_WIDTH-1:0] samp_in;

    generate
        if (NUM_CH == 2) begin : g_dual
            assign en_in   = ch_en;
            assign shdn_in = ch_shdn;
            assign samp_in = data_in;
        end else begin : g_single
            assign en_in   = {1'b0, ch_en};
            assign shdn_in = {1'b0, ch_shdn};
            assign samp_in = {{DATA_WIDTH{1'b0}}, data_in};
        end
    endgenerate

    function automatic logic [15:0] frame_word(input logic c,
                                               input logic [1:0][DATA_WIDTH-1:0] d,
                                               input logic [1:0] sd);
        logic [11:0] s;
        s = 12'(d[c]) << (12 - DATA_WIDTH);
        return {c, BUF_BIT, GAIN_BIT, ~sd[c], s};
    endfunction

    assign rise    = sync2 & ~sync3;
    assign div_end = (cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sck_hi  <= 1'b0;
            sh      <= '0;
            ch      <= 1'b0;
            en_q    <= '0;
            shdn_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1   <= sample_clk;
            sync2   <= sync1;
            sync3   <= sync2;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sck_hi  <= sck_n;
            sh      <= sh_n;
            ch      <= ch_n;
            en_q    <= en_n;
            shdn_q  <= shdn_n;
            data_q  <= data_n;
            done_q  <= done_n;
            ovr_q   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sck_n   = sck_hi;
        sh_n    = sh;
        ch_n    = ch;
        en_n    = en_q;
        shdn_n  = shdn_q;
        data_n  = data_q;
        done_n  = 1'b0;
        ovr_n   = ovr_q | (rise && (state != S_IDLE));

        case (state)
            S_IDLE: begin
                if (rise && |en_in) state_n = S_LOAD;
            end
            S_LOAD: begin
                en_n    = en_in;
                shdn_n  = shdn_in;
                data_n  = samp_in;
                ch_n    = ~en_in[0];
                sh_n    = frame_word(~en_in[0], samp_in, shdn_in);
                cnt_n   = '0;
                state_n = S_SETUP;
            end
            S_SETUP: begin
                if (div_end) begin
                    cnt_n   = '0;
                    sck_n   = 1'b1;
                    bit_n   = 4'd15;
                    state_n = S_SHIFT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_end) begin
                    cnt_n = '0;
                    if (!sck_hi) begin
                        sck_n = 1'b1;
                    end else if (bit_idx == 4'd0) begin
                        sck_n   = 1'b0;
                        state_n = S_HOLD;
                    end else begin
                        // Falling SCK edge: present the next bit.
                        sck_n = 1'b0;
                        bit_n = bit_idx - 1'b1;
                        sh_n  = {sh[14:0], 1'b0};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (div_end) begin
                    cnt_n = '0;
                    if (!ch && en_q[1]) begin
                        ch_n    = 1'b1;
                        sh_n    = frame_word(1'b1, data_q, shdn_q);
                        state_n = S_SETUP;
                    end else begin
                        state_n = S_LDAC;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_LDAC: begin
                if (cnt == LDAC_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        CS_PIN   = 1'b1;
        MOSI_PIN = 1'b0;
        SCK_PIN  = 1'b0;
        if ((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD)) begin
            CS_PIN   = 1'b0;
            MOSI_PIN = sh[15];
            SCK_PIN  = sck_hi && (state == S_SHIFT);
        end
        LDAC_PIN = (state != S_LDAC);
        busy     = (state != S_IDLE);
        done     = done_q;
        overrun  = ovr_q;
    end

endmodule

// File: tb/tb_mcp49xx_dac_driver.sv
// Directed bench for mcp49xx_dac_driver: three parameterisations share clk/reset; a pin monitor decodes frames.
module tb_mcp49xx_dac_driver;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  sc      = 3'b000;
    logic [9:0]  data_a  = '0;
    logic        en_a    = 1'b0;
    logic        shdn_a  = 1'b0;
    logic [23:0] data_b  = '0;
    logic [1:0]  en_b    = '0;
    logic [1:0]  shdn_b  = '0;
    logic [15:0] data_c  = '0;
    logic [1:0]  en_c    = '0;
    logic [1:0]  shdn_c  = '0;
    wire  [2:0]  sck, mosi, cs, ldac, busy, done, ovr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcp49xx_dac_driver u_a (
        .clk(clk), .reset_n(reset_n), .sample_clk(sc[0]),
        .data_in(data_a), .ch_en(en_a), .ch_shdn(shdn_a),
        .SCK_PIN(sck[0]), .MOSI_PIN(mosi[0]), .CS_PIN(cs[0]), .LDAC_PIN(ldac[0]),
        .busy(busy[0]), .done(done[0]), .overrun(ovr[0])
    );

    mcp49xx_dac_driver #(.DATA_WIDTH(12), .NUM_CH(2), .CLK_DIV(2), .LDAC_CYCLES(2)) u_b (
        .clk(clk), .reset_n(reset_n), .sample_clk(sc[1]),
        .data_in(data_b), .ch_en(en_b), .ch_shdn(shdn_b),
        .SCK_PIN(sck[1]), .MOSI_PIN(mosi[1]), .CS_PIN(cs[1]), .LDAC_PIN(ldac[1]),
        .busy(busy[1]), .done(done[1]), .overrun(ovr[1])
    );

    mcp49xx_dac_driver #(.DATA_WIDTH(8), .NUM_CH(2), .CLK_DIV(1), .LDAC_CYCLES(3)) u_c (
        .clk(clk), .reset_n(reset_n), .sample_clk(sc[2]),
        .data_in(data_c), .ch_en(en_c), .ch_shdn(shdn_c),
        .SCK_PIN(sck[2]), .MOSI_PIN(mosi[2]), .CS_PIN(cs[2]), .LDAC_PIN(ldac[2]),
        .busy(busy[2]), .done(done[2]), .overrun(ovr[2])
    );

    // Pin monitor: decodes frames on SCK rises and measures CS/LDAC pulse widths.
    bit   [2:0]  cs_p = 3'b111, sck_p = 3'b000, ldac_p = 3'b111;
    int          cs_cnt[3], hi_cnt[3], gap_last[3], ldac_cnt[3];
    logic [15:0] sh[3];
    logic [15:0] fr[3][16];
    int          cslen[3][16];
    int          gap[3][16];
    int          nfr[3], ldac_len[3], ldac_n[3], done_n[3], sck_viol[3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            cs_p[i]   <= cs[i];
            sck_p[i]  <= sck[i];
            ldac_p[i] <= ldac[i];
            if (!cs[i]) begin
                if (cs_p[i]) begin
                    cs_cnt[i]   <= 1;
                    sh[i]       <= 16'h0000;
                    gap_last[i] <= hi_cnt[i];
                end else begin
                    cs_cnt[i] <= cs_cnt[i] + 1;
                    if (sck[i] && !sck_p[i]) sh[i] <= {sh[i][14:0], mosi[i]};
                end
            end else begin
                hi_cnt[i] <= cs_p[i] ? hi_cnt[i] + 1 : 1;
                if (!cs_p[i]) begin
                    fr[i][nfr[i]]    <= sh[i];
                    cslen[i][nfr[i]] <= cs_cnt[i];
                    gap[i][nfr[i]]   <= gap_last[i];
                    if (nfr[i] < 15) nfr[i] <= nfr[i] + 1;
                end
                if (sck[i]) sck_viol[i] <= sck_viol[i] + 1;
            end
            if (!ldac[i]) begin
                ldac_cnt[i] <= ldac_p[i] ? 1 : ldac_cnt[i] + 1;
            end else if (!ldac_p[i]) begin
                ldac_len[i] <= ldac_cnt[i];
                ldac_n[i]   <= ldac_n[i] + 1;
            end
            if (done[i]) done_n[i] <= done_n[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_update(input int i, input int lb0);
        int n;
        n = 0;
        while (ldac_n[i] == lb0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("update_timeout", 32'(n < 2000), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cs_low(input int i);
        int n;
        n = 0;
        while (cs[i] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cs_low_timeout", 32'(n < 500), 1);
    endtask

    task automatic pulse_sc(input int i);
        sc[i] = 1'b1;
        repeat (3) @(negedge clk);
        sc[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int lb;
        int db;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_pins", 32'({cs[0], sck[0], mosi[0], ldac[0], busy[0], done[0], ovr[0]}), 32'b1001000);
        check("rst_bc_pins", 32'({cs[2:1], sck[2:1], ldac[2:1], busy[2:1], ovr[2:1]}), 32'b1100110000);
        reset_n = 1'b1;

        // Single channel 10-bit full scale, with latency and post-LOAD data change.
        data_a = 10'h3FF; en_a = 1'b1; shdn_a = 1'b0;
        repeat (2) @(negedge clk);
        base = nfr[0]; lb = ldac_n[0]; db = done_n[0];
        sc[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); check("lat_k0_cs", 32'(cs[0]), 1);
        @(negedge clk);
        @(negedge clk); check("lat_k2_cs", 32'(cs[0]), 1);
        @(negedge clk); check("lat_k3_cs", 32'(cs[0]), 0);
        check("lat_k3_busy", 32'(busy[0]), 1);
        @(posedge clk);
        @(posedge clk);
        #1 data_a = 10'h000; sc[0] = 1'b0;
        wait_update(0, lb);
        check("a_frame", 32'(fr[0][base]), 32'h3FFC);
        check("a_nframes", nfr[0] - base, 1);
        check("a_cs_len", cslen[0][base], 66);
        check("a_ldac_len", ldac_len[0], 2);
        check("a_done_cnt", done_n[0] - db, 1);
        check("a_busy_after", 32'(busy[0]), 0);

        // Overrun: second edge mid-frame is dropped.
        data_a = 10'h155;
        base = nfr[0]; lb = ldac_n[0];
        pulse_sc(0);
        wait_cs_low(0);
        repeat (20) @(negedge clk);
        check("ovr_before", 32'(ovr[0]), 0);
        pulse_sc(0);
        check("ovr_set", 32'(ovr[0]), 1);
        wait_update(0, lb);
        repeat (150) @(negedge clk);
        check("ovr_frame", 32'(fr[0][base]), 32'h3554);
        check("ovr_nframes", nfr[0] - base, 1);
        check("ovr_nupdates", ldac_n[0] - lb, 1);

        data_a = 10'h001;
        base = nfr[0]; lb = ldac_n[0];
        pulse_sc(0);
        wait_update(0, lb);
        check("post_ovr_frame", 32'(fr[0][base]), 32'h3004);
        check("ovr_sticky", 32'(ovr[0]), 1);

        // ch_en == 0: edge ignored, no done.
        en_a = 1'b0;
        base = nfr[0]; db = done_n[0];
        pulse_sc(0);
        repeat (100) @(negedge clk);
        check("noen_nframes", nfr[0] - base, 0);
        check("noen_done", done_n[0] - db, 0);
        check("noen_pins", 32'({cs[0], sck[0], ldac[0], busy[0]}), 32'b1010);
        en_a = 1'b1;

        // Reset asserted during bit 7 of a frame.
        data_a = 10'h3FF;
        sc[0] = 1'b1;
        wait_cs_low(0);
        sc[0] = 1'b0;
        repeat (34) @(negedge clk);
        check("bit7_pre", 32'({cs[0], sck[0], mosi[0]}), 32'b011);
        #1 reset_n = 1'b0;
        #1 check("rst_mid_pins", 32'({cs[0], sck[0], mosi[0], ldac[0], busy[0], ovr[0]}), 32'b100100);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        data_a = 10'h2AA;
        base = nfr[0]; lb = ldac_n[0];
        pulse_sc(0);
        wait_update(0, lb);
        check("rst_clean_frame", 32'(fr[0][base]), 32'h3AA8);
        check("rst_clean_cs_len", cslen[0][base], 66);
        check("rst_clean_ovr", 32'(ovr[0]), 0);

        // Dual channel 12-bit, both enabled, B in shutdown.
        data_b = {12'h800, 12'h123}; en_b = 2'b11; shdn_b = 2'b10;
        base = nfr[1]; lb = ldac_n[1]; db = done_n[1];
        pulse_sc(1);
        wait_update(1, lb);
        check("b_nframes", nfr[1] - base, 2);
        check("b_frame0", 32'(fr[1][base]), 32'h3123);
        check("b_frame1", 32'(fr[1][base+1]), 32'hA800);
        check("b_cs_gap", gap[1][base+1], 2);
        check("b_cs_len1", cslen[1][base+1], 66);
        check("b_nupdates", ldac_n[1] - lb, 1);
        check("b_done_cnt", done_n[1] - db, 1);

        // Dual channel 8-bit, only B enabled, D=1, 3-cycle LDAC.
        data_c = {8'hA5, 8'h3C}; en_c = 2'b10; shdn_c = 2'b00;
        base = nfr[2]; lb = ldac_n[2];
        pulse_sc(2);
        wait_update(2, lb);
        check("c_nframes", nfr[2] - base, 1);
        check("c_frame", 32'(fr[2][base]), 32'hBA50);
        check("c_cs_len", cslen[2][base], 33);
        check("c_ldac_len", ldac_len[2], 3);

        check("sck_while_cs_high", sck_viol[0] + sck_viol[1] + sck_viol[2], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
